// File: rtl/counter_disp_pkg.sv
// Shared constants for the BCD cascade display: active-low 7-segment codes,
// idle levels for the segment and digit-enable buses, and the scan states.
// Declarations only: no logic, no latency, no flow control.
package counter_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] DIG_OFF   = 4'hF;

    // Segment order is g..a, active-low, bit 0 = a
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern with a blank override.
// Purely combinational, zero latency; no flow control.
module seg7_decode
    import counter_disp_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_val)
                4'h0: o_seg = SEG_HEX_0;
                4'h1: o_seg = SEG_HEX_1;
                4'h2: o_seg = SEG_HEX_2;
                4'h3: o_seg = SEG_HEX_3;
                4'h4: o_seg = SEG_HEX_4;
                4'h5: o_seg = SEG_HEX_5;
                4'h6: o_seg = SEG_HEX_6;
                4'h7: o_seg = SEG_HEX_7;
                4'h8: o_seg = SEG_HEX_8;
                4'h9: o_seg = SEG_HEX_9;
                4'hA: o_seg = SEG_HEX_A;
                4'hB: o_seg = SEG_HEX_B;
                4'hC: o_seg = SEG_HEX_C;
                4'hD: o_seg = SEG_HEX_D;
                4'hE: o_seg = SEG_HEX_E;
                default: o_seg = SEG_HEX_F;
            endcase
        end
    end

endmodule

// File: rtl/bcd_cascade_display.sv
// Three cascaded BCD digits driven by the upstream carry, plus a 4-digit scanned display.
// Counter updates on the sampling edge; segments/enables lag the scan index by one cycle.
// No backpressure: i_cin is consumed every cycle it is high, the display free-runs.
module bcd_cascade_display #(
    parameter int P_SCAN_DIV = 50000,
    parameter bit P_BLANK    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_cnt,
    input  logic        i_cin,
    input  logic        i_clr,
    output logic [11:0] o_bcd,
    output logic        o_ovf,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_dig_sel
);
    import counter_disp_pkg::*;

    logic [3:0]  r_d1, r_d2, r_d3;
    logic        r_ovf;
    logic [15:0] r_presc;
    scan_state_t r_state;
    logic [6:0]  r_seg;
    logic [3:0]  r_dig_sel;

    logic        w_d1_wrap, w_d2_wrap, w_d3_wrap;
    logic        w_presc_wrap;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_seg;

    assign w_d1_wrap    = (r_d1 == 4'd9);
    assign w_d2_wrap    = (r_d2 == 4'd9);
    assign w_d3_wrap    = (r_d3 == 4'd9);
    assign w_presc_wrap = (r_presc == 16'(P_SCAN_DIV - 1));

    // Carry ripples through all three digits within a single edge
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_d3  <= 4'd0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_d3  <= 4'd0;
            r_ovf <= 1'b0;
        end else if (i_cin) begin
            r_ovf <= w_d1_wrap && w_d2_wrap && w_d3_wrap;
            r_d1  <= w_d1_wrap ? 4'd0 : r_d1 + 4'd1;
            if (w_d1_wrap) begin
                r_d2 <= w_d2_wrap ? 4'd0 : r_d2 + 4'd1;
            end
            if (w_d1_wrap && w_d2_wrap) begin
                r_d3 <= w_d3_wrap ? 4'd0 : r_d3 + 4'd1;
            end
        end else begin
            r_ovf <= 1'b0;
        end
    end

    // Leading-zero blanking cascades down from digit 3; digit 0 always shows
    always_comb begin
        w_digit = i_cnt;
        w_blank = 1'b0;
        case (r_state)
            SCAN_D0: begin
                w_digit = i_cnt;
                w_blank = 1'b0;
            end
            SCAN_D1: begin
                w_digit = r_d1;
                w_blank = P_BLANK && (r_d3 == 4'd0) && (r_d2 == 4'd0) && (r_d1 == 4'd0);
            end
            SCAN_D2: begin
                w_digit = r_d2;
                w_blank = P_BLANK && (r_d3 == 4'd0) && (r_d2 == 4'd0);
            end
            default: begin
                w_digit = r_d3;
                w_blank = P_BLANK && (r_d3 == 4'd0);
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_val   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc   <= 16'd0;
            r_state   <= SCAN_D0;
            r_seg     <= SEG_BLANK;
            r_dig_sel <= DIG_OFF;
        end else begin
            r_presc <= w_presc_wrap ? 16'd0 : r_presc + 16'd1;
            if (w_presc_wrap) begin
                case (r_state)
                    SCAN_D0: r_state <= SCAN_D1;
                    SCAN_D1: r_state <= SCAN_D2;
                    SCAN_D2: r_state <= SCAN_D3;
                    default: r_state <= SCAN_D0;
                endcase
            end
            r_seg     <= w_seg;
            r_dig_sel <= ~(4'b0001 << r_state);
        end
    end

    assign o_bcd     = {r_d3, r_d2, r_d1};
    assign o_ovf     = r_ovf;
    assign o_seg     = r_seg;
    assign o_dig_sel = r_dig_sel;

endmodule
